// File: rtl/wb_arbiter.sv
// Writeback stage: holds one ALU and one load result, formats loads, arbitrates
// round-robin and drives the register-file write port one write per cycle.
module wb_arbiter #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [RADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]    alu_result,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    input  logic [2:0]         mem_funct3,
    input  logic [2:0]         mem_addr_lo,
    output logic               write_sig,
    output logic [RADDR_W-1:0] write_reg,
    output logic [XLEN-1:0]    write_val,
    output logic               wb_error,
    output logic [CNT_W-1:0]   wb_count
);

    typedef struct packed {
        logic               vld;
        logic               nowr;
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    val;
    } entry_t;

    typedef enum logic {SRC_ALU, SRC_MEM} src_e;

    entry_t alu_h, mem_h, sel;
    src_e   last_grant;
    logic   grant_alu, grant_mem;

    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_w;
    logic [XLEN-1:0] ld_val;
    logic            ld_bad;

    // On a conflict the source that did not win last time goes next.
    always_comb begin
        grant_alu = alu_h.vld && (!mem_h.vld || last_grant == SRC_MEM);
        grant_mem = mem_h.vld && (!alu_h.vld || last_grant == SRC_ALU);
        sel       = grant_mem ? mem_h : alu_h;
    end

    assign alu_ready = !reset && (!alu_h.vld || grant_alu);
    assign mem_ready = !reset && (!mem_h.vld || grant_mem);

    always_comb begin
        ld_b   = 8'(mem_data >> {mem_addr_lo, 3'b000});
        ld_h   = 16'(mem_data >> {mem_addr_lo[2:1], 4'b0000});
        ld_w   = mem_addr_lo[2] ? mem_data[63:32] : mem_data[31:0];
        ld_val = '0;
        ld_bad = 1'b0;
        case (mem_funct3)
            3'b000: ld_val = {{(XLEN-8){ld_b[7]}}, ld_b};
            3'b001: begin ld_val = {{(XLEN-16){ld_h[15]}}, ld_h}; ld_bad = mem_addr_lo[0]; end
            3'b010: begin ld_val = {{(XLEN-32){ld_w[31]}}, ld_w}; ld_bad = |mem_addr_lo[1:0]; end
            3'b011: begin ld_val = mem_data; ld_bad = |mem_addr_lo; end
            3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_b};
            3'b101: begin ld_val = {{(XLEN-16){1'b0}}, ld_h}; ld_bad = mem_addr_lo[0]; end
            3'b110: begin ld_val = {{(XLEN-32){1'b0}}, ld_w}; ld_bad = |mem_addr_lo[1:0]; end
            default: ld_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_h      <= '0;
            mem_h      <= '0;
            last_grant <= SRC_ALU;
            write_sig  <= 1'b0;
            write_reg  <= '0;
            write_val  <= '0;
            wb_error   <= 1'b0;
            wb_count   <= '0;
        end else begin
            if (alu_valid && alu_ready)
                alu_h <= '{vld: 1'b1, nowr: 1'b0, rd: alu_rd, val: alu_result};
            else if (grant_alu)
                alu_h.vld <= 1'b0;

            // Bad loads still occupy the slot so the upstream handshake stays simple.
            if (mem_valid && mem_ready) begin
                mem_h <= '{vld: 1'b1, nowr: ld_bad, rd: mem_rd, val: ld_bad ? '0 : ld_val};
                if (ld_bad)
                    wb_error <= 1'b1;
            end else if (grant_mem) begin
                mem_h.vld <= 1'b0;
            end

            if (grant_alu || grant_mem) begin
                last_grant <= grant_mem ? SRC_MEM : SRC_ALU;
                write_reg  <= sel.rd;
                write_val  <= sel.val;
                write_sig  <= !sel.nowr && (sel.rd != '0);
            end else begin
                write_sig  <= 1'b0;
            end

            if (write_sig)
                wb_count <= wb_count + CNT_W'(1);
        end
    end

endmodule
